// File: rtl/lm_sequencer.sv
// Load-multiple sequencer: turns one start request (base address plus
// register mask) into a chain of single-outstanding memory reads, each
// followed by one register file write, in ascending register order.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             one-cycle request, honoured only while idle
//   base_addr         word address of the lowest selected register
//   reg_mask          bit i selects Ri; bit 7 (R7) is ignored
//   mem_rd_en         one-cycle read request to data memory
//   mem_addr          read address, held between requests
//   mem_rd_data       read data from memory
//   mem_rd_valid      read data strobe, honoured only while waiting
//   rf_write_en       one-cycle register file write strobe
//   rf_write_address  destination register (0..6), held between writes
//   rf_write_data     captured read data, held between writes
//   busy              high whenever a request is in progress
//   done              one-cycle pulse closing every accepted request

module lm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [7:0]  reg_mask,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        rf_write_en,
    output logic [2:0]  rf_write_address,
    output logic [15:0] rf_write_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [6:0]  r_mask;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_rd_en;
    logic [15:0] r_mem_addr;
    logic        r_we;
    logic [2:0]  r_wa;
    logic        r_busy;
    logic        r_done;

    logic [2:0]  w_low_idx;
    logic [6:0]  w_mask_next;
    logic [15:0] w_addr_inc;

    // Index of the lowest pending register; scanning downward lets
    // the last hit (the lowest set bit) win.
    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // Clearing the lowest set bit retires the register just written.
    assign w_mask_next = r_mask & (r_mask - 7'd1);
    assign w_addr_inc  = r_addr + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mask     <= 7'd0;
            r_addr     <= 16'd0;
            r_data     <= 16'd0;
            r_rd_en    <= 1'b0;
            r_mem_addr <= 16'd0;
            r_we       <= 1'b0;
            r_wa       <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= base_addr;
                        r_mask <= reg_mask[6:0];
                        r_busy <= 1'b1;
                        if (reg_mask[6:0] == 7'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rd_en    <= 1'b1;
                            r_mem_addr <= base_addr;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rd_valid) begin
                        r_data  <= mem_rd_data;
                        r_we    <= 1'b1;
                        r_wa    <= w_low_idx;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_we   <= 1'b0;
                    r_mask <= w_mask_next;
                    r_addr <= w_addr_inc;
                    if (w_mask_next == 7'd0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rd_en    <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                        r_state    <= S_REQ;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_we    <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en        = r_rd_en;
    assign mem_addr         = r_mem_addr;
    assign rf_write_en      = r_we;
    assign rf_write_address = r_wa;
    assign rf_write_data    = r_data;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule
